// File: rtl/mmul_pkg.sv
// Shared definitions for the N x N matrix multiplier: FSM encoding and width helpers.
package mmul_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD_A = 3'd1,
        LOAD_B = 3'd2,
        CALC   = 3'd3,
        OUT    = 3'd4
    } mmul_state_e;

    // Ceiling log2; returns 1 for v <= 2 so index fields never collapse to zero width.
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        while ((32'd1 << r) < v) r++;
        return (r == 0) ? 1 : r;
    endfunction

    function automatic int unsigned acc_width(input int unsigned n, input int unsigned dw);
        return 2 * dw + clog2(n);
    endfunction

endpackage

// File: rtl/mmul_mac.sv
// Signed multiply-accumulate with clear; result narrowed to 2*DW (saturating when MMUL_SAT_EN is defined).
module mmul_mac
    import mmul_pkg::*;
#(
    parameter int unsigned DW    = 8,
    parameter int unsigned ACC_W = 17
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 clr,
    input  logic signed [DW-1:0] a,
    input  logic signed [DW-1:0] b,
    output logic [2*DW-1:0]      res_c
);

    localparam int unsigned PW = 2 * DW;

    logic signed [PW-1:0]    prod;
    logic        [ACC_W-1:0] prod_ext;
    logic        [ACC_W-1:0] acc_q;
    logic        [ACC_W-1:0] acc_d;
    logic        [ACC_W-PW:0] acc_hi;

    assign prod     = a * b;
    assign prod_ext = {{(ACC_W-PW){prod[PW-1]}}, prod};
    assign acc_hi   = acc_q[ACC_W-1:PW-1];

    // Clear restarts the sum with the current product rather than zero.
    always_comb begin
        acc_d = acc_q;
        if (en) begin
            acc_d = (clr ? {ACC_W{1'b0}} : acc_q) + prod_ext;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

`ifdef MMUL_SAT_EN
    always_comb begin
        res_c = acc_q[PW-1:0];
        if (!((&acc_hi) || !(|acc_hi))) begin
            res_c = acc_q[ACC_W-1] ? {1'b1, {(PW-1){1'b0}}} : {1'b0, {(PW-1){1'b1}}};
        end
    end
`else
    always_comb begin
        res_c = acc_q[PW-1:0];
        if (acc_hi == '0) begin
            res_c = acc_q[PW-1:0];
        end
    end
`endif

endmodule

// File: rtl/mmul_nxn.sv
// N x N signed matrix multiplier: streams in A then B, runs N^3 MACs, streams out C with handshake.
// Define MMUL_SAT_EN to saturate results to the signed 2*DW range instead of wrapping.
module mmul_nxn
    import mmul_pkg::*;
#(
    parameter int unsigned N  = 2,
    parameter int unsigned DW = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_rdy,
    input  logic [DW-1:0]   in_data,
    output logic            read_in,
    output logic            out_rdy,
    output logic [2*DW-1:0] out_data,
    output logic            out_last,
    input  logic            out_ack,
    output logic            busy
);

    localparam int unsigned ACC_W = acc_width(N, DW);
    localparam int unsigned NN    = N * N;
    localparam int unsigned IW    = clog2(N);
    localparam int unsigned CW    = clog2(NN);
    localparam int unsigned OW    = 2 * DW;

    mmul_state_e state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [IW-1:0] i_q, i_d, j_q, j_d, k_q, k_d;
    logic [CW-1:0] out_idx_q, out_idx_d;
    logic [CW-1:0] st_idx_q, st_idx_d;
    logic          st_q, st_d;
    logic          out_rdy_q, out_rdy_d;
    logic          out_last_q, out_last_d;
    logic [OW-1:0] out_data_q, out_data_d;
    logic          read_in_q, read_in_d;
    logic          busy_q, busy_d;

    logic [DW-1:0] a_q [NN];
    logic [DW-1:0] a_d [NN];
    logic [DW-1:0] b_q [NN];
    logic [DW-1:0] b_d [NN];
    logic [OW-1:0] c_q [NN];
    logic [OW-1:0] c_d [NN];

    logic          accept;
    logic          mac_en, mac_clr;
    logic [DW-1:0] mac_a, mac_b;
    logic [OW-1:0] mac_res;

    function automatic logic [CW-1:0] idx(input logic [IW-1:0] r, input logic [IW-1:0] c);
        return CW'(r) * CW'(N) + CW'(c);
    endfunction

    assign accept = in_rdy && read_in_q;
    assign mac_a  = a_q[idx(i_q, k_q)];
    assign mac_b  = b_q[idx(k_q, j_q)];

    mmul_mac #(
        .DW    (DW),
        .ACC_W (ACC_W)
    ) u_mac (
        .clk   (clk),
        .rst   (rst),
        .en    (mac_en),
        .clr   (mac_clr),
        .a     (mac_a),
        .b     (mac_b),
        .res_c (mac_res)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        i_d        = i_q;
        j_d        = j_q;
        k_d        = k_q;
        out_idx_d  = out_idx_q;
        st_idx_d   = st_idx_q;
        st_d       = 1'b0;
        out_rdy_d  = out_rdy_q;
        out_last_d = out_last_q;
        out_data_d = out_data_q;
        a_d        = a_q;
        b_d        = b_q;
        c_d        = c_q;
        mac_en     = 1'b0;
        mac_clr    = 1'b0;

        // A finished dot product lands in the MAC register one cycle after its last term.
        if (st_q) c_d[st_idx_q] = mac_res;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    a_d[0]  = in_data;
                    cnt_d   = CW'(1);
                    state_d = LOAD_A;
                end
            end
            LOAD_A: begin
                if (accept) begin
                    a_d[cnt_q] = in_data;
                    if (cnt_q == CW'(NN - 1)) begin
                        cnt_d   = '0;
                        state_d = LOAD_B;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            LOAD_B: begin
                if (accept) begin
                    b_d[cnt_q] = in_data;
                    if (cnt_q == CW'(NN - 1)) begin
                        cnt_d   = '0;
                        i_d     = '0;
                        j_d     = '0;
                        k_d     = '0;
                        state_d = CALC;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            CALC: begin
                mac_en  = 1'b1;
                mac_clr = (k_q == '0);
                if (k_q == IW'(N - 1)) begin
                    st_d     = 1'b1;
                    st_idx_d = idx(i_q, j_q);
                    k_d      = '0;
                    if (j_q == IW'(N - 1)) begin
                        j_d = '0;
                        if (i_q == IW'(N - 1)) begin
                            i_d     = '0;
                            state_d = OUT;
                        end else begin
                            i_d = i_q + IW'(1);
                        end
                    end else begin
                        j_d = j_q + IW'(1);
                    end
                end else begin
                    k_d = k_q + IW'(1);
                end
            end
            OUT: begin
                if (!out_rdy_q) begin
                    out_rdy_d  = 1'b1;
                    out_last_d = 1'b0;
                    out_idx_d  = '0;
                    out_data_d = c_q[0];
                end else if (out_ack) begin
                    if (out_last_q) begin
                        out_rdy_d  = 1'b0;
                        out_last_d = 1'b0;
                        state_d    = IDLE;
                    end else begin
                        out_idx_d  = out_idx_q + CW'(1);
                        out_data_d = c_q[out_idx_q + CW'(1)];
                        out_last_d = ((out_idx_q + CW'(1)) == CW'(NN - 1));
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        read_in_d = (state_d == IDLE) || (state_d == LOAD_A) || (state_d == LOAD_B);
        busy_d    = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            i_q        <= '0;
            j_q        <= '0;
            k_q        <= '0;
            out_idx_q  <= '0;
            st_idx_q   <= '0;
            st_q       <= 1'b0;
            out_rdy_q  <= 1'b0;
            out_last_q <= 1'b0;
            out_data_q <= '0;
            read_in_q  <= 1'b1;
            busy_q     <= 1'b0;
            for (int n = 0; n < int'(NN); n++) c_q[n] <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            i_q        <= i_d;
            j_q        <= j_d;
            k_q        <= k_d;
            out_idx_q  <= out_idx_d;
            st_idx_q   <= st_idx_d;
            st_q       <= st_d;
            out_rdy_q  <= out_rdy_d;
            out_last_q <= out_last_d;
            out_data_q <= out_data_d;
            read_in_q  <= read_in_d;
            busy_q     <= busy_d;
            c_q        <= c_d;
        end
    end

    // Operand storage is fully reloaded before use, so it carries no reset.
    always_ff @(posedge clk) begin
        a_q <= a_d;
        b_q <= b_d;
    end

    assign read_in  = read_in_q;
    assign out_rdy  = out_rdy_q;
    assign out_last = out_last_q;
    assign out_data = out_data_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_mmul_nxn.sv
// Directed, table-driven bench for mmul_nxn at N=2, DW=8 (honours MMUL_SAT_EN for the overflow vector).
module tb_mmul_nxn;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_rdy;
    logic [7:0]  in_data;
    logic        read_in;
    logic        out_rdy;
    logic [15:0] out_data;
    logic        out_last;
    logic        out_ack;
    logic        busy;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       name;
        logic [7:0]  a [4];
        logic [7:0]  b [4];
        logic [15:0] c [4];
    } vec_t;

    vec_t vecs [4];

    always #5 clk = ~clk;

    mmul_nxn #(.N(2), .DW(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_rdy   (in_rdy),
        .in_data  (in_data),
        .read_in  (read_in),
        .out_rdy  (out_rdy),
        .out_data (out_data),
        .out_last (out_last),
        .out_ack  (out_ack),
        .busy     (busy)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic load(input int v);
        for (int e = 0; e < 8; e++) begin
            in_rdy  = 1'b1;
            in_data = (e < 4) ? vecs[v].a[e] : vecs[v].b[e-4];
            @(posedge clk); #1;
            if (e == 0) chk({vecs[v].name, "_busy_load"}, 32'(busy), 32'd1);
        end
        in_rdy = 1'b0;
    endtask

    task automatic run_op(input int v, input int stall);
        int cyc;
        load(v);
        in_rdy  = 1'b1;
        in_data = 8'h55;
        cyc = 0;
        while (!out_rdy && cyc < 50) begin
            @(posedge clk); #1;
            cyc++;
            if (cyc == 1) chk({vecs[v].name, "_read_in_calc"}, 32'(read_in), 32'd0);
        end
        in_rdy = 1'b0;
        if (!out_rdy) begin
            chk({vecs[v].name, "_out_rdy_timeout"}, 32'(out_rdy), 32'd1);
            return;
        end
        chk({vecs[v].name, "_latency"}, 32'(cyc), 32'd9);
        for (int r = 0; r < 4; r++) begin
            if (r == stall) begin
                out_ack = 1'b0;
                for (int s = 0; s < 5; s++) begin
                    @(posedge clk); #1;
                    chk({vecs[v].name, "_hold_data"}, 32'(out_data), 32'(vecs[v].c[r]));
                    chk({vecs[v].name, "_hold_rdy"}, 32'(out_rdy), 32'd1);
                end
            end
            chk($sformatf("%s_data%0d", vecs[v].name, r), 32'(out_data), 32'(vecs[v].c[r]));
            chk($sformatf("%s_last%0d", vecs[v].name, r), 32'(out_last), 32'(r == 3));
            chk($sformatf("%s_rdy%0d", vecs[v].name, r), 32'(out_rdy), 32'd1);
            out_ack = 1'b1;
            @(posedge clk); #1;
            out_ack = 1'b0;
        end
        chk({vecs[v].name, "_rdy_done"}, 32'(out_rdy), 32'd0);
        chk({vecs[v].name, "_last_done"}, 32'(out_last), 32'd0);
        chk({vecs[v].name, "_busy_done"}, 32'(busy), 32'd0);
        chk({vecs[v].name, "_read_in_done"}, 32'(read_in), 32'd1);
    endtask

    initial begin
        rst     = 1'b0;
        in_rdy  = 1'b0;
        in_data = '0;
        out_ack = 1'b0;

        vecs[0].name = "ident";
        vecs[0].a = '{8'd1, 8'd0, 8'd0, 8'd1};
        vecs[0].b = '{8'd1, 8'd0, 8'd0, 8'd1};
        vecs[0].c = '{16'h0001, 16'h0000, 16'h0000, 16'h0001};
        vecs[1].name = "general";
        vecs[1].a = '{8'd1, 8'd2, 8'd3, 8'd4};
        vecs[1].b = '{8'd5, 8'd6, 8'd7, 8'd8};
        vecs[1].c = '{16'h0013, 16'h0016, 16'h002B, 16'h0032};
        vecs[2].name = "signed";
        vecs[2].a = '{8'hFF, 8'h00, 8'h00, 8'hFF};
        vecs[2].b = '{8'd3, 8'd4, 8'd5, 8'd6};
        vecs[2].c = '{16'hFFFD, 16'hFFFC, 16'hFFFB, 16'hFFFA};
        vecs[3].name = "overflow";
        vecs[3].a = '{8'h80, 8'h80, 8'h80, 8'h80};
        vecs[3].b = '{8'h80, 8'h80, 8'h80, 8'h80};
`ifdef MMUL_SAT_EN
        vecs[3].c = '{16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF};
`else
        vecs[3].c = '{16'h8000, 16'h8000, 16'h8000, 16'h8000};
`endif

        repeat (2) @(posedge clk); #1;
        chk("rst_out_rdy", 32'(out_rdy), 32'd0);
        chk("rst_out_last", 32'(out_last), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_read_in", 32'(read_in), 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;

        for (int v = 0; v < 4; v++) run_op(v, -1);

        // Back-pressure on the second result.
        run_op(1, 1);

        // Abandon an operation mid-CALC, then reload and check a clean result.
        load(3);
        repeat (3) @(posedge clk);
        #1;
        chk("midcalc_busy_before", 32'(busy), 32'd1);
        rst = 1'b0;
        #1;
        chk("midcalc_busy", 32'(busy), 32'd0);
        chk("midcalc_out_rdy", 32'(out_rdy), 32'd0);
        chk("midcalc_read_in", 32'(read_in), 32'd1);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        chk("midcalc_idle_busy", 32'(busy), 32'd0);
        chk("midcalc_idle_out_rdy", 32'(out_rdy), 32'd0);
        run_op(1, -1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mmul_nxn.md
MMUL_NXN -- requirements
Module: mmul_nxn

Interface
REQ-001 SHALL have parameter N, default 2, meaning matrix dimension (legal 2..4).
REQ-002 SHALL have parameter DW, default 8, meaning signed two's-complement element width.
REQ-003 SHALL have derived localparam ACC_W = 2*DW + clog2(N), the internal accumulator width.
REQ-004 SHALL have port clk, input, 1, the single clock; all logic rising-edge.
REQ-005 SHALL have port rst, input, 1, reset: asynchronous, active-low.
REQ-006 SHALL have port in_rdy, input, 1, producer element valid.
REQ-007 SHALL have port in_data, input, DW, element value; A then B, each row-major.
REQ-008 SHALL have port read_in, output, 1, block can accept an element.
REQ-009 SHALL have port out_rdy, output, 1, result element valid.
REQ-010 SHALL have port out_data, output, 2*DW, result element value, row-major.
REQ-011 SHALL have port out_last, output, 1, marks the final (N-1,N-1) result.
REQ-012 SHALL have port out_ack, input, 1, consumer accepts the result.
REQ-013 SHALL have port busy, output, 1, high in every state except IDLE.

Function
REQ-014 SHALL implement FSM IDLE -> LOAD_A -> LOAD_B -> CALC -> OUT -> IDLE.
REQ-015 SHALL leave IDLE for LOAD_A on the first accepted element; that element is stored as A[0][0].
REQ-016 SHALL accept an element only on edges where in_rdy && read_in; in_rdy with read_in low is ignored.
REQ-017 SHALL drive read_in high only in IDLE, LOAD_A and LOAD_B.
REQ-018 SHALL take LOAD_A -> LOAD_B after N*N accepted elements, and LOAD_B -> CALC after N*N more.
REQ-019 SHALL compute in CALC C[i][j] = sum_k A[i][k]*B[k][j] with one signed MAC per cycle; CALC lasts exactly N*N*N cycles.
REQ-020 SHALL accumulate at ACC_W bits with no intermediate overflow.
REQ-021 SHALL raise out_rdy the cycle after CALC ends, N^3+1 cycles after the edge accepting the last B element.
REQ-022 SHALL advance to the next result on an edge with out_rdy && out_ack.
REQ-023 SHALL hold out_data and out_last stable while out_rdy && !out_ack.
REQ-024 SHALL return to IDLE on the edge where the out_last element is acknowledged, dropping out_rdy that cycle.
REQ-025 SHALL, after each completed transfer, start a new operation with both A and B reloaded.
REQ-026 SHALL keep out_rdy and out_last low outside OUT.

Reset
REQ-027 SHALL, on rst low at any time including mid-LOAD, CALC or OUT, enter IDLE immediately, abandoning the operation.
REQ-028 SHALL reset out_rdy=0, out_last=0, out_data=0, busy=0 and read_in=1, and clear all counters and accumulators.
REQ-029 SHALL require a full A+B reload after reset; element storage contents are don't-care.

Configuration
REQ-030 SHALL, with MMUL_SAT_EN defined, clamp each ACC_W result to the signed 2*DW range [-2^(2DW-1), 2^(2DW-1)-1].
REQ-031 SHALL, without MMUL_SAT_EN, output the low 2*DW bits of the accumulator (wrap).

Structure
REQ-032 SHALL place the FSM state encoding and the ACC_W/clog2 helper in shared package mmul_pkg.
REQ-033 SHALL use one sub-module mmul_mac (signed multiply-accumulate with clear) instantiated once.

Verification (N=2, DW=8)
REQ-034 SHALL cover identity: A=[1,0,0,1], B=[1,0,0,1] -> out 1,0,0,1; out_last on the 4th; first out_rdy 9 cycles after the last B.
REQ-035 SHALL cover general values: A=[1,2,3,4], B=[5,6,7,8] -> 19,22,43,50 (0x0013,0x0016,0x002B,0x0032).
REQ-036 SHALL cover signed values: A=[0xFF,0,0,0xFF], B=[3,4,5,6] -> 0xFFFD,0xFFFC,0xFFFB,0xFFFA.
REQ-037 SHALL cover overflow: A=B=all 0x80 -> 0x7FFF x4 with MMUL_SAT_EN, 0x8000 x4 without.
REQ-038 SHALL cover back-pressure: out_ack low 5 cycles on result 2 -> out_data held at 22; no element lost or duplicated.
REQ-039 SHALL cover mid-CALC reset: rst low 2 cycles during CALC -> busy=0, out_rdy=0, read_in=1; the next A/B load yields correct results.
